dp_operand_sequencer: RTL and testbench

- Sequencing stage wrapped around the 4x16-bit → 34-bit combinational datapath netlist (ports in1..in4 / out1).
- Upstream side: accepts a valid/ready stream of 16-bit operand words. Registers them into four stable operand buses that drive the datapath directly.
- Waits a programmable settle time, then captures the 34-bit datapath result.
- Downstream side: presents the captured result on a valid/ready output.

---
 rtl/dp_operand_sequencer_pkg.sv | 19 +
 rtl/dp_operand_sequencer_if.sv | 27 ++
 rtl/dp_operand_sequencer_result_slice.sv | 33 +++
 rtl/dp_operand_sequencer.sv | 123 ++++++++++++
 tb/tb_dp_operand_sequencer.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/dp_operand_sequencer_pkg.sv
// Shared types and constants for the operand sequencer around the
// 4x16-bit -> 34-bit datapath.
package dp_seq_pkg;

    localparam int DEF_OP_W  = 16;
    localparam int DEF_RES_W = 34;
    localparam int NUM_OPS   = 4;

    typedef enum logic [1:0] {
        LOAD,
        SETTLE,
        CAPTURE,
        OUT
    } state_t;

    typedef logic [1:0] idx_t;
    typedef logic [3:0] cnt_t;

endpackage

// File: rtl/dp_operand_sequencer_if.sv
// Operand input stream and result output stream of the sequencer.
// The slave modport is the sequencer's view, master is the environment's.
interface dp_operand_sequencer_if
    import dp_seq_pkg::*;
#(
    parameter int OP_W  = DEF_OP_W,
    parameter int RES_W = DEF_RES_W
);
    logic             s_valid;
    logic             s_ready;
    logic [OP_W-1:0]  s_data;
    logic             s_last;
    logic             m_valid;
    logic             m_ready;
    logic [RES_W-1:0] m_data;

    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_data
    );

    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_data
    );

endinterface

// File: rtl/dp_operand_sequencer_result_slice.sv
// Result output register: loads on capture, holds until the downstream
// valid/ready handshake completes.
module dp_result_slice #(
    parameter int RES_W = 34
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             capture,
    input  logic [RES_W-1:0] d,
    input  logic             ready,
    output logic             valid,
    output logic [RES_W-1:0] q
);

    logic             valid_reg;
    logic [RES_W-1:0] data_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
        end else if (capture) begin
            valid_reg <= 1'b1;
            data_reg  <= d;
        end else if (valid_reg && ready) begin
            valid_reg <= 1'b0;
        end
    end

    assign valid = valid_reg;
    assign q     = data_reg;

endmodule

// File: rtl/dp_operand_sequencer.sv
// Loads four operand words, lets the datapath settle, captures its result.
// Optional short frames (s_last) are enabled by DP_OPSEQ_SHORT_FRAME_EN.
module dp_operand_sequencer
    import dp_seq_pkg::*;
#(
    parameter int OP_W          = DEF_OP_W,
    parameter int RES_W         = DEF_RES_W,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dp_operand_sequencer_if.slave bus,
    output logic [OP_W-1:0]       dp_in1,
    output logic [OP_W-1:0]       dp_in2,
    output logic [OP_W-1:0]       dp_in3,
    output logic [OP_W-1:0]       dp_in4,
    input  logic [RES_W-1:0]      dp_out1
);

    state_t state_reg, state_next;
    idx_t   idx_reg, idx_next;
    cnt_t   cnt_reg, cnt_next;
    logic   s_ready_reg;
    logic   capture;
    logic   accept;
    logic   last_word;
    logic   frame_end;

    logic [OP_W-1:0] op_reg [NUM_OPS];

    assign accept = bus.s_valid && s_ready_reg;

`ifdef DP_OPSEQ_SHORT_FRAME_EN
    assign last_word = bus.s_last;
`else
    assign last_word = 1'b0;
`endif

    assign frame_end = accept && ((idx_reg == idx_t'(NUM_OPS - 1)) || last_word);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= LOAD;
            idx_reg     <= '0;
            cnt_reg     <= '0;
            s_ready_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            idx_reg     <= idx_next;
            cnt_reg     <= cnt_next;
            s_ready_reg <= (state_next == LOAD);
        end
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        cnt_next   = cnt_reg;
        capture    = 1'b0;
        case (state_reg)
            LOAD: begin
                if (frame_end) begin
                    idx_next   = '0;
                    cnt_next   = cnt_t'(SETTLE_CYCLES);
                    state_next = SETTLE;
                end else if (accept) begin
                    idx_next = idx_reg + 1'b1;
                end
            end
            SETTLE: begin
                if (cnt_reg == '0) begin
                    state_next = CAPTURE;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            CAPTURE: begin
                capture    = 1'b1;
                state_next = OUT;
            end
            OUT: begin
                if (bus.m_valid && bus.m_ready) begin
                    state_next = LOAD;
                end
            end
            default: state_next = LOAD;
        endcase
    end

    // A short frame zeroes every operand above the terminating word.
    generate
        for (genvar gi = 0; gi < NUM_OPS; gi++) begin : g_op
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    op_reg[gi] <= '0;
                end else if (accept && (idx_reg == idx_t'(gi))) begin
                    op_reg[gi] <= bus.s_data;
                end else if (frame_end && (gi > int'(idx_reg))) begin
                    op_reg[gi] <= '0;
                end
            end
        end
    endgenerate

    assign dp_in1      = op_reg[0];
    assign dp_in2      = op_reg[1];
    assign dp_in3      = op_reg[2];
    assign dp_in4      = op_reg[3];
    assign bus.s_ready = s_ready_reg;

    dp_result_slice #(
        .RES_W(RES_W)
    ) u_result (
        .clk    (clk),
        .rst_n  (rst_n),
        .capture(capture),
        .d      (dp_out1),
        .ready  (bus.m_ready),
        .valid  (bus.m_valid),
        .q      (bus.m_data)
    );

endmodule

// File: tb/tb_dp_operand_sequencer.sv
// Directed bench: instance A (settle 2, sum datapath), instance B (settle 0,
// product-sum datapath).
module tb_dp_operand_sequencer;
    import dp_seq_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dp_operand_sequencer_if ifa ();
    dp_operand_sequencer_if ifb ();

    logic [15:0] a_in1, a_in2, a_in3, a_in4;
    logic [15:0] b_in1, b_in2, b_in3, b_in4;
    logic [33:0] a_out, b_out;

    assign a_out = 34'(a_in1) + 34'(a_in2) + 34'(a_in3) + 34'(a_in4);
    assign b_out = 34'(b_in1) * 34'(b_in2) + 34'(b_in3) * 34'(b_in4);

    dp_operand_sequencer #(.SETTLE_CYCLES(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa),
        .dp_in1(a_in1), .dp_in2(a_in2), .dp_in3(a_in3), .dp_in4(a_in4),
        .dp_out1(a_out)
    );

    dp_operand_sequencer #(.SETTLE_CYCLES(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb),
        .dp_in1(b_in1), .dp_in2(b_in2), .dp_in3(b_in3), .dp_in4(b_in4),
        .dp_out1(b_out)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one word on instance A (sel=0) or B (sel=1) until it is accepted.
    task automatic send(input bit sel, input logic [15:0] d, input bit last);
        int n = 0;
        if (sel) begin
            ifb.s_valid = 1'b1; ifb.s_data = d; ifb.s_last = last;
            while (!ifb.s_ready && n < 20) begin step(); n++; end
            check("send_b_ready", ifb.s_ready, 1);
            step();
            ifb.s_valid = 1'b0; ifb.s_last = 1'b0;
        end else begin
            ifa.s_valid = 1'b1; ifa.s_data = d; ifa.s_last = last;
            while (!ifa.s_ready && n < 20) begin step(); n++; end
            check("send_a_ready", ifa.s_ready, 1);
            step();
            ifa.s_valid = 1'b0; ifa.s_last = 1'b0;
        end
        $display("tb: sent 0x%04h to %s", d, sel ? "B" : "A");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        ifa.s_valid = 1'b0; ifa.s_data = '0; ifa.s_last = 1'b0; ifa.m_ready = 1'b0;
        ifb.s_valid = 1'b0; ifb.s_data = '0; ifb.s_last = 1'b0; ifb.m_ready = 1'b0;

        // Reset state
        repeat (3) step();
        check("rst_s_ready", ifa.s_ready, 0);
        check("rst_m_valid", ifa.m_valid, 0);
        check("rst_m_data", ifa.m_data, 0);
        check("rst_dp_in1", a_in1, 0);
        check("rst_dp_in4", a_in4, 0);
        rst_n = 1'b1;
        step();
        check("post_rst_s_ready_a", ifa.s_ready, 1);
        check("post_rst_s_ready_b", ifb.s_ready, 1);

        // Frame 1,2,3,4 with m_ready high; m_valid exactly 4 edges after last accept
        ifa.m_ready = 1'b1;
        send(0, 16'h0001, 0); send(0, 16'h0002, 0); send(0, 16'h0003, 0); send(0, 16'h0004, 0);
        check("f1_dp_in1", a_in1, 1);
        check("f1_dp_in2", a_in2, 2);
        check("f1_dp_in3", a_in3, 3);
        check("f1_dp_in4", a_in4, 4);
        check("f1_m_valid_t0", ifa.m_valid, 0);
        check("f1_s_ready_t0", ifa.s_ready, 0);
        for (int k = 1; k <= 4; k++) begin
            step();
            check($sformatf("f1_m_valid_t%0d", k), ifa.m_valid, (k == 4) ? 1 : 0);
        end
        check("f1_m_data", ifa.m_data, 34'h0000_0000A);
        check("f1_s_ready_out", ifa.s_ready, 0);
        step();
        check("f1_m_valid_done", ifa.m_valid, 0);
        check("f1_s_ready_done", ifa.s_ready, 1);

        // Back-pressure: m_ready low for 10 cycles
        ifa.m_ready = 1'b0;
        send(0, 16'h0001, 0); send(0, 16'h0002, 0); send(0, 16'h0003, 0); send(0, 16'h0004, 0);
        repeat (4) step();
        check("bp_m_valid_rise", ifa.m_valid, 1);
        for (int k = 0; k < 10; k++) begin
            step();
            check("bp_m_valid_hold", ifa.m_valid, 1);
            check("bp_m_data_hold", ifa.m_data, 34'hA);
            check("bp_s_ready_low", ifa.s_ready, 0);
        end
        ifa.m_ready = 1'b1;
        step();
        check("bp_m_valid_clear", ifa.m_valid, 0);
        check("bp_s_ready_rise", ifa.s_ready, 1);

        // Instance B: SETTLE_CYCLES=0, all-ones operands
        ifb.m_ready = 1'b1;
        for (int k = 0; k < 4; k++) send(1, 16'hFFFF, 0);
        step();
        check("b_m_valid_t1", ifb.m_valid, 0);
        step();
        check("b_m_valid_t2", ifb.m_valid, 1);
        check("b_m_data", ifb.m_data, 34'h1_FFFC_0002);
        step();
        check("b_m_valid_done", ifb.m_valid, 0);

        // Reset in the middle of a frame
        send(0, 16'h0005, 0); send(0, 16'h0006, 0);
        check("mid_dp_in1_pre", a_in1, 5);
        check("mid_dp_in2_pre", a_in2, 6);
        rst_n = 1'b0;
        #2;
        check("mid_rst_dp_in1", a_in1, 0);
        check("mid_rst_dp_in2", a_in2, 0);
        check("mid_rst_m_data", ifa.m_data, 0);
        check("mid_rst_m_valid", ifa.m_valid, 0);
        check("mid_rst_s_ready", ifa.s_ready, 0);
        step();
        rst_n = 1'b1;
        step();
        send(0, 16'h0005, 0); send(0, 16'h0006, 0); send(0, 16'h0007, 0); send(0, 16'h0008, 0);
        repeat (4) step();
        check("mid_next_m_valid", ifa.m_valid, 1);
        check("mid_next_m_data", ifa.m_data, 34'h1A);
        step();

        // s_valid held during SETTLE/OUT is not consumed
        ifa.m_ready = 1'b0;
        send(0, 16'h0009, 0); send(0, 16'h000A, 0); send(0, 16'h000B, 0); send(0, 16'h000C, 0);
        ifa.s_valid = 1'b1; ifa.s_data = 16'hDEAD;
        repeat (6) step();
        check("hold_dp_in1", a_in1, 16'h0009);
        check("hold_m_valid", ifa.m_valid, 1);
        check("hold_m_data", ifa.m_data, 34'h2A);
        check("hold_s_ready", ifa.s_ready, 0);
        ifa.m_ready = 1'b1;
        step();
        check("hold_hs_dp_in1", a_in1, 16'h0009);
        check("hold_hs_s_ready", ifa.s_ready, 1);
        check("hold_hs_m_valid", ifa.m_valid, 0);
        step();
        check("hold_dead_in1", a_in1, 16'hDEAD);
        ifa.s_valid = 1'b0;
        send(0, 16'h0001, 0); send(0, 16'h0002, 0); send(0, 16'h0003, 0);
        repeat (4) step();
        check("dead_m_valid", ifa.m_valid, 1);
        check("dead_m_data", ifa.m_data, 34'hDEB3);
        step();

`ifdef DP_OPSEQ_SHORT_FRAME_EN
        // Short frame terminated by s_last on the 2nd word
        send(0, 16'h0001, 0); send(0, 16'h0002, 0); send(0, 16'h0003, 0); send(0, 16'h0004, 0);
        repeat (5) step();
        send(0, 16'h0010, 0); send(0, 16'h0020, 1);
        check("short_dp_in1", a_in1, 16'h0010);
        check("short_dp_in2", a_in2, 16'h0020);
        check("short_dp_in3", a_in3, 0);
        check("short_dp_in4", a_in4, 0);
        repeat (4) step();
        check("short_m_valid", ifa.m_valid, 1);
        check("short_m_data", ifa.m_data, 34'h30);
        step();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
